// File: rtl/wb_periph_interconnect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect_pkg
// Description : Shared types, constants and slot-decode helpers for the
//               Wishbone peripheral interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_interconnect_pkg;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } wb_state_e;

  // Read data returned on an error termination.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // The slot index is carried at its widest size (16 slots -> 4 bits).
  localparam int unsigned IDX_W = 4;

  // Extract the slot index field: addr[lsb +: sel_w], zero-extended to IDX_W.
  function automatic logic [IDX_W-1:0] slot_index(input logic [63:0]  addr,
                                                  input int unsigned  lsb,
                                                  input int unsigned  sel_w);
    return IDX_W'((addr >> lsb) & ((64'd1 << sel_w) - 64'd1));
  endfunction

  // A slot is usable when it exists and is marked as populated.
  function automatic logic slot_valid(input logic [IDX_W-1:0] idx,
                                      input logic [15:0]      mask,
                                      input int unsigned      nslaves);
    return (32'(idx) < nslaves) && mask[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_periph_interconnect_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Watchdog cycle counter with clear/load/enable. expired_o is
//               high while the count sits on TIMEOUT_CYCLES-1; a value of 0
//               for TIMEOUT_CYCLES disables expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             enable_i,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over load, load over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/wb_periph_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : wb_periph_interconnect
// Description : Wishbone classic 1-master / N-slave peripheral interconnect
//               with registered transaction FSM, population mask, bus-error
//               termination of unmapped slots and a slave-ack watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_periph_interconnect
  import wb_interconnect_pkg::*;
#(
  parameter int unsigned           NUM_SLAVES     = 8,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           SLOT_LSB       = 8,
  parameter logic [15:0]           SLAVE_MASK     = 16'hFFFF,
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cyc_i,
  input  logic                             stb_i,
  input  logic                             we_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             ack_o,
  output logic                             err_o,
  output logic [NUM_SLAVES-1:0]            slv_cyc_o,
  output logic [NUM_SLAVES-1:0]            slv_stb_o,
  output logic                             slv_we_o,
  output logic [ADDR_WIDTH-1:0]            slv_addr_o,
  output logic [DATA_WIDTH-1:0]            slv_data_o,
  input  logic [NUM_SLAVES-1:0]            slv_ack_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_data_i,
  output logic [7:0]                       err_count_o,
  output logic [ADDR_WIDTH-1:0]            last_err_addr_o
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  wb_state_e               state_q, state_d;
  logic [IDX_W-1:0]        sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   last_err_q, last_err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    we_q, we_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]        req_idx;
  logic                    req_valid;
  logic [NUM_SLAVES-1:0]   sel_onehot;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    sel_ack;
  logic                    tmo_expired;
  logic                    go_err;
  logic [ADDR_WIDTH-1:0]   go_err_addr;

  // Decode the slot of the incoming master request.
  always_comb begin
    req_idx   = slot_index(64'(addr_i), SLOT_LSB, SEL_W);
    req_valid = slot_valid(req_idx, SLAVE_MASK, NUM_SLAVES);
  end

  // One-hot select and read-data mux for the latched slot.
  always_comb begin
    sel_onehot = '0;
    sel_rdata  = '0;
    for (int k = 0; k < int'(NUM_SLAVES); k++) begin
      if (sel_q == IDX_W'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_rdata     = slv_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the selected slave's ack counts.
  assign sel_ack = |(slv_ack_i & sel_onehot);

  // Watchdog runs only while waiting on a slave; it restarts from zero on entry.
  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (state_q != BUSY),
    .load_i     (1'b0),
    .load_val_i ('0),
    .enable_i   (state_q == BUSY),
    .expired_o  (tmo_expired)
  );

  // Next-state and datapath logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    last_err_d  = last_err_q;
    go_err      = 1'b0;
    go_err_addr = addr_q;

    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          sel_d   = req_idx;
          addr_d  = addr_i;
          wdata_d = data_i;
          we_d    = we_i;
          if (req_valid) begin
            state_d = BUSY;
          end else begin
            go_err      = 1'b1;
            go_err_addr = addr_i;
          end
        end
      end
      BUSY: begin
        // Abort beats a same-cycle ack: the master has walked away.
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          state_d = RESP;
          ack_d   = 1'b1;
          if (!we_q) begin
            rdata_d = sel_rdata;
          end
        end else if (tmo_expired) begin
          go_err = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared error termination for unmapped slots and watchdog expiry.
    if (go_err) begin
      state_d    = ERR;
      ack_d      = 1'b1;
      err_d      = 1'b1;
      rdata_d    = ERR_DATA;
      last_err_d = go_err_addr;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request, response and error-statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      last_err_q <= '0;
    end else begin
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      last_err_q <= last_err_d;
    end
  end

  assign slv_cyc_o       = (state_q == BUSY) ? sel_onehot : '0;
  assign slv_stb_o       = (state_q == BUSY) ? sel_onehot : '0;
  assign slv_we_o        = we_q;
  assign slv_addr_o      = addr_q;
  assign slv_data_o      = wdata_q;
  assign data_o          = rdata_q;
  assign ack_o           = ack_q;
  assign err_o           = err_q;
  assign err_count_o     = err_cnt_q;
  assign last_err_addr_o = last_err_q;

endmodule
`default_nettype wire
